// File: rtl/block_char_feeder.sv
// rtl/block_char_feeder.sv - byte FIFO feeding the block checker one character per clock, releasing whole words only
module block_char_feeder #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [7:0]  out_char,
    output logic        out_valid,
    output logic [15:0] word_count,
    output logic        word_split
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FORCE
    } state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_ZERO = '0;
    localparam logic [7:0]  FILLER   = 8'd32;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   delim_cnt;
    state_t        state;
    state_t        state_nxt;
    logic          prev_letter;
    logic          push;
    logic          pop;
    logic          empty;
    logic          full;
    logic          split_evt;
    logic          in_letter;
    logic          head_letter;
    logic          push_delim;
    logic          pop_delim;
    logic [7:0]    head;

    assign empty       = (count == CNT_ZERO);
    assign full        = (count == FULL_CNT);
    assign in_ready    = !full;
    assign push        = in_valid && !full;
    assign head        = mem[rd_ptr];
    assign in_letter   = ((in_data >= 8'd65) && (in_data <= 8'd90)) ||
                         ((in_data >= 8'd97) && (in_data <= 8'd122));
    assign head_letter = ((head >= 8'd65) && (head <= 8'd90)) ||
                         ((head >= 8'd97) && (head <= 8'd122));
    assign push_delim  = push && !in_letter;
    assign pop_delim   = pop && !head_letter;

    // A word starts only when its delimiter is already buffered, or when it
    // has filled the FIFO and must be forced out.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        split_evt = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty && (delim_cnt != CNT_ZERO)) begin
                    pop       = 1'b1;
                    state_nxt = S_RUN;
                end else if (full) begin
                    pop       = 1'b1;
                    state_nxt = S_FORCE;
                end
            end
            S_RUN: begin
                pop = !empty;
            end
            S_FORCE: begin
                pop       = !empty;
                split_evt = empty;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (pop && !head_letter) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            delim_cnt   <= '0;
            state       <= S_IDLE;
            prev_letter <= 1'b0;
            out_char    <= FILLER;
            out_valid   <= 1'b0;
            word_count  <= '0;
            word_split  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            case ({push_delim, pop_delim})
                2'b10:   delim_cnt <= delim_cnt + CNT_ONE;
                2'b01:   delim_cnt <= delim_cnt - CNT_ONE;
                default: delim_cnt <= delim_cnt;
            endcase
            if (pop) begin
                out_char    <= head;
                out_valid   <= 1'b1;
                prev_letter <= head_letter;
                if (!head_letter && prev_letter) begin
                    word_count <= word_count + 16'd1;
                end
            end else begin
                out_char  <= FILLER;
                out_valid <= 1'b0;
            end
            if (split_evt) begin
                word_split <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_block_char_feeder.sv
// tb/tb_block_char_feeder.sv - directed bench for block_char_feeder (DEPTH 16 and DEPTH 4 instances)
module tb_block_char_feeder;

    logic        clk = 1'b0;
    logic        a_reset, a_in_valid, a_in_ready, a_out_valid, a_word_split;
    logic [7:0]  a_in_data, a_out_char;
    logic [15:0] a_word_count;
    logic        b_reset, b_in_valid, b_in_ready, b_out_valid, b_word_split;
    logic [7:0]  b_in_data, b_out_char;
    logic [15:0] b_word_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    block_char_feeder #(.DEPTH(16), .AW(4)) dut_a (
        .clk(clk), .reset(a_reset), .in_valid(a_in_valid), .in_data(a_in_data),
        .in_ready(a_in_ready), .out_char(a_out_char), .out_valid(a_out_valid),
        .word_count(a_word_count), .word_split(a_word_split)
    );

    block_char_feeder #(.DEPTH(4), .AW(2)) dut_b (
        .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .out_char(b_out_char), .out_valid(b_out_valid),
        .word_count(b_word_count), .word_split(b_word_split)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic v, input logic [7:0] d);
        if (sel) begin
            b_in_valid = v;
            b_in_data  = d;
        end else begin
            a_in_valid = v;
            a_in_data  = d;
        end
    endtask

    task automatic chk_status(input bit sel, input string tag, input logic [15:0] wc,
                              input logic split, input logic rdy);
        chk({tag, " word_count"}, sel ? b_word_count : a_word_count, wc);
        chk({tag, " word_split"}, {15'd0, sel ? b_word_split : a_word_split}, {15'd0, split});
        chk({tag, " in_ready"}, {15'd0, sel ? b_in_ready : a_in_ready}, {15'd0, rdy});
    endtask

    // '_' in ins means no byte offered; '_' in exps means filler (space, out_valid=0)
    task automatic run(input bit sel, input string tag, input string ins, input string exps);
        logic       v;
        logic [7:0] d;
        logic [7:0] e;
        logic [7:0] oc;
        logic       ov;
        for (int i = 0; i < exps.len(); i++) begin
            v = 1'b0;
            d = 8'd0;
            if (i < ins.len()) begin
                if (ins[i] != 8'd95) begin
                    v = 1'b1;
                    d = ins[i];
                end
            end
            drive(sel, v, d);
            tick();
            e  = exps[i];
            oc = sel ? b_out_char : a_out_char;
            ov = sel ? b_out_valid : a_out_valid;
            if (e == 8'd95) begin
                chk($sformatf("%s[%0d] char", tag, i), {8'd0, oc}, 16'd32);
                chk($sformatf("%s[%0d] valid", tag, i), {15'd0, ov}, 16'd0);
            end else begin
                chk($sformatf("%s[%0d] char", tag, i), {8'd0, oc}, {8'd0, e});
                chk($sformatf("%s[%0d] valid", tag, i), {15'd0, ov}, 16'd1);
            end
        end
        drive(sel, 1'b0, 8'd0);
    endtask

    initial begin
        a_reset = 1'b1; b_reset = 1'b1;
        a_in_valid = 1'b1; a_in_data = 8'd32;
        b_in_valid = 1'b1; b_in_data = 8'd32;
        tick();
        tick();
        a_reset = 1'b0; b_reset = 1'b0;
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        chk("a reset char", {8'd0, a_out_char}, 16'd32);
        chk("a reset valid", {15'd0, a_out_valid}, 16'd0);
        chk_status(1'b0, "a reset", 16'd0, 1'b0, 1'b1);
        chk("b reset char", {8'd0, b_out_char}, 16'd32);
        chk_status(1'b1, "b reset", 16'd0, 1'b0, 1'b1);
        // bytes offered during reset must not appear
        run(1'b0, "a post-reset", "", "___");

        run(1'b0, "t1", "Begin end ", "______Begin end ____");
        chk_status(1'b0, "t1", 16'd2, 1'b0, 1'b1);

        run(1'b0, "t2", "beg__________in ", "________________begin __");
        chk_status(1'b0, "t2", 16'd3, 1'b0, 1'b1);

        run(1'b0, "t4a", "  ", "_  ");
        chk_status(1'b0, "t4a", 16'd3, 1'b0, 1'b1);
        run(1'b0, "t4b", "x,,y.", "__x,,y.__");
        chk_status(1'b0, "t4b", 16'd5, 1'b0, 1'b1);

        run(1'b0, "t5", "ab cccc ", "___ab __cccc __");
        chk_status(1'b0, "t5", 16'd7, 1'b0, 1'b1);

        run(1'b1, "t3 fill", "abcd", "____");
        chk_status(1'b1, "t3 full", 16'd0, 1'b0, 1'b0);
        run(1'b1, "t3 force", "_____", "abcd_");
        chk_status(1'b1, "t3 split", 16'd0, 1'b1, 1'b1);
        run(1'b1, "t3 tail", "e ", "_e _");
        chk_status(1'b1, "t3 tail", 16'd1, 1'b1, 1'b1);

        run(1'b1, "t6 fill", "fghi", "____f");
        b_reset    = 1'b1;
        b_in_valid = 1'b1;
        b_in_data  = 8'd32;
        tick();
        b_reset    = 1'b0;
        b_in_valid = 1'b0;
        chk("t6 char", {8'd0, b_out_char}, 16'd32);
        chk("t6 valid", {15'd0, b_out_valid}, 16'd0);
        chk_status(1'b1, "t6", 16'd0, 1'b0, 1'b1);
        run(1'b1, "t6 drain", "", "_____");
        run(1'b1, "t6 fresh", "ok.", "___ok.__");
        chk_status(1'b1, "t6 fresh", 16'd1, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
